afe_pulser_burst: RTL and testbench

Next-generation AFE pulser word generator in the divclk domain. It drives N_CH independent OSERDES word streams of SER_W bits each. Each channel has its own bit-resolution start delay, width, enable and idle level. Channels fire together as a burst of n_pulses pulses spaced period words apart. Trigger synchronisation and edge detection (lclk to divclk) stay outside the block, and each out_words lane feeds one AFE_PULSER_OUTPUT-style OSERDES.

---
 rtl/afe_pulser_pkg.sv | 28 ++
 rtl/afe_pulser_word_gen.sv | 29 ++
 rtl/afe_pulser_burst.sv | 143 ++++++++++++++
 tb/tb_afe_pulser_burst.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pulser_pkg.sv
// Shared definitions for the AFE pulser burst generator.
//   state_t        : burst FSM state encoding
//   SER_W_DEF      : default OSERDES word width (bit 0 serialised first)
//   CNT_W_DEF      : default width of delay/width/period/n_pulses fields
//   bit_in_window  : true when a bit position lies in [delay, delay+width)
package afe_pulser_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam int unsigned SER_W_DEF = 8;
   localparam int unsigned CNT_W_DEF = 16;

   // Wide enough that k*SER_W+j and delay+width never wrap for any
   // practical CNT_W/SER_W combination.
   localparam int unsigned CMP_W = 64;

   function automatic logic bit_in_window(
      input logic [CMP_W-1:0] pos,
      input logic [CMP_W-1:0] delay,
      input logic [CMP_W-1:0] width
   );
      return (pos >= delay) && (pos < (delay + width));
   endfunction

endpackage

// File: rtl/afe_pulser_word_gen.sv
// Combinational single-channel word generator.
// Ports:
//   k     in  CNT_W  word index within the current period
//   delay in  CNT_W  pulse start offset in bits
//   width in  CNT_W  pulse width in bits
//   en    in  1      channel enable; 0 forces an all-zero word
//   word  out SER_W  pulse bits for word k (bit 0 serialised first)
module afe_pulser_word_gen
   import afe_pulser_pkg::*;
#(
   parameter int unsigned SER_W = SER_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic [CNT_W-1:0] k,
   input  logic [CNT_W-1:0] delay,
   input  logic [CNT_W-1:0] width,
   input  logic             en,
   output logic [SER_W-1:0] word
);

   always_comb begin
      word = '0;
      for (int unsigned j = 0; j < SER_W; j++) begin
         word[j] = en & bit_in_window(CMP_W'(k) * CMP_W'(SER_W) + CMP_W'(j),
                                      CMP_W'(delay), CMP_W'(width));
      end
   end

endmodule

// File: rtl/afe_pulser_burst.sv
// AFE pulser burst word generator (divclk domain).
// Ports:
//   divclk       in  1            word clock, rising edge
//   divclk_rst   in  1            synchronous active-high reset
//   trig         in  1            single-cycle trigger (already synchronised)
//   abort        in  1            synchronous burst abort
//   ch_en        in  N_CH         per-channel enable (latched at trigger)
//   y0           in  N_CH         per-channel idle level (live, not latched)
//   width        in  N_CH*CNT_W   per-channel pulse width in bits
//   delay        in  N_CH*CNT_W   per-channel start offset in bits
//   period       in  CNT_W        pulse spacing in words (0 treated as 1)
//   n_pulses     in  CNT_W        pulses per burst (0 treated as 1)
//   out_words    out N_CH*SER_W   OSERDES words, ch i at [i*SER_W +: SER_W]
//   busy         out 1            burst in progress
//   trig_ignored out 1            one-cycle flag: trigger rejected
module afe_pulser_burst
   import afe_pulser_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned SER_W = SER_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                    divclk,
   input  logic                    divclk_rst,
   input  logic                    trig,
   input  logic                    abort,
   input  logic [N_CH-1:0]         ch_en,
   input  logic [N_CH-1:0]         y0,
   input  logic [N_CH*CNT_W-1:0]   width,
   input  logic [N_CH*CNT_W-1:0]   delay,
   input  logic [CNT_W-1:0]        period,
   input  logic [CNT_W-1:0]        n_pulses,
   output logic [N_CH*SER_W-1:0]   out_words,
   output logic                    busy,
   output logic                    trig_ignored
);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        wcnt_q, wcnt_d;
   logic [CNT_W-1:0]        pcnt_q, pcnt_d;
   logic [CNT_W-1:0]        period_q, period_d;
   logic [N_CH-1:0]         en_q, en_d;
   logic [N_CH*CNT_W-1:0]   width_q, width_d;
   logic [N_CH*CNT_W-1:0]   delay_q, delay_d;
   logic [N_CH*SER_W-1:0]   pulse_bits_q, pulse_bits_d;
   logic                    busy_q, busy_d;
   logic                    trig_ignored_q, trig_ignored_d;
   logic [N_CH*SER_W-1:0]   gen_words;
   logic                    accept;

   // The word generators look at next-cycle config and word index so the
   // registered pulse_bits present word k in the same cycle wcnt_q == k,
   // and the first word appears the cycle after the accepting edge.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      afe_pulser_word_gen #(
         .SER_W (SER_W),
         .CNT_W (CNT_W)
      ) u_word_gen (
         .k     (wcnt_d),
         .delay (delay_d[i*CNT_W +: CNT_W]),
         .width (width_d[i*CNT_W +: CNT_W]),
         .en    (en_d[i]),
         .word  (gen_words[i*SER_W +: SER_W])
      );
   end

   always_comb begin
      accept         = (state_q == S_IDLE) && trig && !abort;
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      pcnt_d         = pcnt_q;
      period_d       = period_q;
      en_d           = en_q;
      width_d        = width_q;
      delay_d        = delay_q;
      trig_ignored_d = trig && ((state_q == S_RUN) || abort);

      if (abort) begin
         state_d = S_IDLE;
         wcnt_d  = '0;
         pcnt_d  = '0;
      end else if (accept) begin
         en_d     = ch_en;
         width_d  = width;
         delay_d  = delay;
         period_d = (period == '0) ? CNT_W'(1) : period;
         pcnt_d   = (n_pulses == '0) ? CNT_W'(1) : n_pulses;
         wcnt_d   = '0;
         state_d  = S_RUN;
      end else if (state_q == S_RUN) begin
         if (wcnt_q == period_q - CNT_W'(1)) begin
            wcnt_d = '0;
            pcnt_d = pcnt_q - CNT_W'(1);
            if (pcnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
            end
         end else begin
            wcnt_d = wcnt_q + CNT_W'(1);
         end
      end

      busy_d       = (state_d == S_RUN);
      pulse_bits_d = busy_d ? gen_words : '0;
   end

   always_ff @(posedge divclk) begin
      if (divclk_rst) begin
         state_q        <= S_IDLE;
         wcnt_q         <= '0;
         pcnt_q         <= '0;
         period_q       <= '0;
         en_q           <= '0;
         width_q        <= '0;
         delay_q        <= '0;
         pulse_bits_q   <= '0;
         busy_q         <= 1'b0;
         trig_ignored_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         pcnt_q         <= pcnt_d;
         period_q       <= period_d;
         en_q           <= en_d;
         width_q        <= width_d;
         delay_q        <= delay_d;
         pulse_bits_q   <= pulse_bits_d;
         busy_q         <= busy_d;
         trig_ignored_q <= trig_ignored_d;
      end
   end

   // Idle level applied after the register so a y0 change shows at once.
   always_comb begin
      out_words = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         out_words[i*SER_W +: SER_W] = pulse_bits_q[i*SER_W +: SER_W] ^ {SER_W{y0[i]}};
      end
   end

   assign busy         = busy_q;
   assign trig_ignored = trig_ignored_q;

endmodule

// File: tb/tb_afe_pulser_burst.sv
// Self-checking bench for afe_pulser_burst (N_CH=4, SER_W=8, CNT_W=16).
module tb_afe_pulser_burst;

   logic         clk = 1'b0;
   logic         rst;
   logic         trig;
   logic         abort;
   logic [3:0]   ch_en;
   logic [3:0]   y0;
   logic [63:0]  width;
   logic [63:0]  delay;
   logic [15:0]  period;
   logic [15:0]  n_pulses;
   logic [31:0]  out_words;
   logic         busy;
   logic         trig_ignored;

   typedef struct packed {
      logic [31:0] w;
      logic        b;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   tests = 0;
   int   fails = 0;

   afe_pulser_burst #(
      .N_CH  (4),
      .SER_W (8),
      .CNT_W (16)
   ) dut (
      .divclk       (clk),
      .divclk_rst   (rst),
      .trig         (trig),
      .abort        (abort),
      .ch_en        (ch_en),
      .y0           (y0),
      .width        (width),
      .delay        (delay),
      .period       (period),
      .n_pulses     (n_pulses),
      .out_words    (out_words),
      .busy         (busy),
      .trig_ignored (trig_ignored)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fire();
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   task automatic sb_push(input logic [31:0] w, input logic b);
      exp_t x;
      x.w = w;
      x.b = b;
      sb.push_back(x);
   endtask

   function automatic logic [31:0] idle_words();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[i*8 +: 8] = {8{y0[i]}};
      return r;
   endfunction

   // Reference word for index k from the bench's current configuration.
   function automatic logic [31:0] model_words(input int k);
      logic [31:0] r;
      longint pos, d, w;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         d = longint'(delay[i*16 +: 16]);
         w = longint'(width[i*16 +: 16]);
         for (int j = 0; j < 8; j++) begin
            pos = longint'(k) * 8 + longint'(j);
            r[i*8 + j] = (ch_en[i] && pos >= d && pos < d + w) ^ y0[i];
         end
      end
      return r;
   endfunction

   task automatic push_burst();
      int p, n;
      p = (period == 0) ? 1 : int'(period);
      n = (n_pulses == 0) ? 1 : int'(n_pulses);
      for (int r = 0; r < n; r++)
         for (int k = 0; k < p; k++) sb_push(model_words(k), 1'b1);
      sb_push(idle_words(), 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; trig = 1'b1; abort = 1'b0;
      ch_en = 4'hF; y0 = 4'b0101; width = '1; delay = '0;
      period = 16'd4; n_pulses = 16'd1;
      tick(); tick();
      tests++;
      if (out_words !== 32'h00FF00FF || busy !== 1'b0 || trig_ignored !== 1'b0) begin
         fails++;
         $display("FAIL reset: out_words=%h busy=%b ign=%b expected 00ff00ff 0 0",
                  out_words, busy, trig_ignored);
      end
      trig = 1'b0; rst = 1'b0;
      tick();
      tests++;
      if (out_words !== 32'h00FF00FF || busy !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: out_words=%h busy=%b expected 00ff00ff 0", out_words, busy);
      end
   endtask

   task automatic test_single();
      ch_en = 4'b0001; y0 = 4'b0000; width = '0; delay = '0;
      width[15:0] = 16'd11; period = 16'd4; n_pulses = 16'd1;
      sb_push(32'h000000FF, 1'b1);
      sb_push(32'h00000007, 1'b1);
      sb_push(32'h00000000, 1'b1);
      sb_push(32'h00000000, 1'b1);
      sb_push(32'h00000000, 1'b0);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL single_pre_busy: busy=%b expected 0", busy);
      end
      fire();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b || trig_ignored !== 1'b0) begin
            fails++;
            $display("FAIL single: out_words=%h busy=%b ign=%b expected %h %b 0",
                     out_words, busy, trig_ignored, e.w, e.b);
         end
         tick();
      end
   endtask

   task automatic test_two_ch();
      ch_en = 4'b0011; y0 = 4'b0000; width = '0; delay = '0;
      delay[15:0] = 16'd6;  width[15:0]  = 16'd4;
      delay[31:16] = 16'd3; width[31:16] = 16'd2;
      period = 16'd2; n_pulses = 16'd1;
      sb_push(32'h000018C0, 1'b1);
      sb_push(32'h00000003, 1'b1);
      sb_push(32'h00000000, 1'b0);
      fire();
      // config changes after acceptance must not affect the running burst
      ch_en = 4'b0000; width = '0; period = 16'd9; n_pulses = 16'd5;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b) begin
            fails++;
            $display("FAIL two_ch: out_words=%h busy=%b expected %h %b",
                     out_words, busy, e.w, e.b);
         end
         tick();
      end
   endtask

   task automatic test_idle_level();
      ch_en = 4'b0001; y0 = 4'b1011; width = '0; delay = '0;
      width[15:0] = 16'd1; period = 16'd2; n_pulses = 16'd3;
      #1;
      tests++;
      if (out_words !== 32'hFF00FFFF) begin
         fails++;
         $display("FAIL idle_pre: out_words=%h expected ff00ffff", out_words);
      end
      for (int r = 0; r < 3; r++) begin
         sb_push(32'hFF00FFFE, 1'b1);
         sb_push(32'hFF00FFFF, 1'b1);
      end
      sb_push(32'hFF00FFFF, 1'b0);
      fire();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b) begin
            fails++;
            $display("FAIL idle_level: out_words=%h busy=%b expected %h %b",
                     out_words, busy, e.w, e.b);
         end
         tick();
      end
      y0 = 4'b0100;
      #1;
      tests++;
      if (out_words !== 32'h00FF0000) begin
         fails++;
         $display("FAIL y0_live: out_words=%h expected 00ff0000", out_words);
      end
   endtask

   task automatic test_trunc();
      ch_en = 4'b0111; y0 = 4'b0000; width = '0; delay = '0;
      width[15:0]  = 16'd20;
      delay[31:16] = 16'd8;  width[31:16] = 16'd4;      // silent: delay >= period*8
      delay[47:32] = 16'd2;  width[47:32] = 16'hFFFF;   // delay+width exceeds 16 bits
      period = 16'd1; n_pulses = 16'd2;
      sb_push(32'h00FC00FF, 1'b1);
      sb_push(32'h00FC00FF, 1'b1);
      sb_push(32'h00000000, 1'b0);
      fire();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b) begin
            fails++;
            $display("FAIL trunc: out_words=%h busy=%b expected %h %b",
                     out_words, busy, e.w, e.b);
         end
         tick();
      end
      period = 16'd0; n_pulses = 16'd0;
      sb_push(32'h00FC00FF, 1'b1);
      sb_push(32'h00000000, 1'b0);
      fire();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b) begin
            fails++;
            $display("FAIL zero_cfg: out_words=%h busy=%b expected %h %b",
                     out_words, busy, e.w, e.b);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      ch_en = 4'b1001; y0 = 4'b0000; width = '0; delay = '0;
      delay[15:0]  = 16'd4;  width[15:0]  = 16'd12;
      delay[63:48] = 16'd17; width[63:48] = 16'd3;
      period = 16'd3; n_pulses = 16'd4;
      push_burst();
      fire();
      for (int idx = 0; idx < 13; idx++) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b || trig_ignored !== (idx == 6)) begin
            fails++;
            $display("FAIL b2b_first idx=%0d: out_words=%h busy=%b ign=%b expected %h %b %b",
                     idx, out_words, busy, trig_ignored, e.w, e.b, (idx == 6));
         end
         // idx 5: trig mid-burst; idx 12: first cycle with busy low
         if (idx == 5 || idx == 12) trig = 1'b1;
         tick();
         trig = 1'b0;
      end
      push_burst();
      while (sb.size() > 0) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b || trig_ignored !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second: out_words=%h busy=%b ign=%b expected %h %b 0",
                     out_words, busy, trig_ignored, e.w, e.b);
         end
         tick();
      end
   endtask

   task automatic test_abort();
      ch_en = 4'b0001; y0 = 4'b0010; width = '0; delay = '0;
      width[15:0] = 16'd6; period = 16'd4; n_pulses = 16'd2;
      push_burst();
      fire();
      for (int idx = 0; idx < 6; idx++) begin
         e = sb.pop_front();
         tests++;
         if (out_words !== e.w || busy !== e.b) begin
            fails++;
            $display("FAIL abort_pre idx=%0d: out_words=%h busy=%b expected %h %b",
                     idx, out_words, busy, e.w, e.b);
         end
         if (idx == 5) abort = 1'b1;
         tick();
         abort = 1'b0;
      end
      sb.delete();
      tests++;
      if (out_words !== 32'h0000FF00 || busy !== 1'b0 || trig_ignored !== 1'b0) begin
         fails++;
         $display("FAIL abort: out_words=%h busy=%b ign=%b expected 0000ff00 0 0",
                  out_words, busy, trig_ignored);
      end
      tick();
      tests++;
      if (out_words !== 32'h0000FF00 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_stays: out_words=%h busy=%b expected 0000ff00 0", out_words, busy);
      end

      fire();
      tick(); tick();
      tests++;
      if (busy !== 1'b1 || out_words !== 32'h0000FF00) begin
         fails++;
         $display("FAIL rst_pre: out_words=%h busy=%b expected 0000ff00 1", out_words, busy);
      end
      rst = 1'b1; trig = 1'b1;
      tick();
      rst = 1'b0; trig = 1'b0;
      tests++;
      if (out_words !== 32'h0000FF00 || busy !== 1'b0 || trig_ignored !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid: out_words=%h busy=%b ign=%b expected 0000ff00 0 0",
                  out_words, busy, trig_ignored);
      end

      trig = 1'b1; abort = 1'b1;
      tick();
      trig = 1'b0; abort = 1'b0;
      tests++;
      if (trig_ignored !== 1'b1 || busy !== 1'b0 || out_words !== 32'h0000FF00) begin
         fails++;
         $display("FAIL trig_abort: ign=%b busy=%b out_words=%h expected 1 0 0000ff00",
                  trig_ignored, busy, out_words);
      end
      tick();
      tests++;
      if (trig_ignored !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL trig_abort_after: ign=%b busy=%b expected 0 0", trig_ignored, busy);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_ch();
      test_idle_level();
      test_trunc();
      test_back_to_back();
      test_abort();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
